// File: rtl/mems_pkg.sv
// Shared types and constants for the MEMS DAC SPI arbiter.
package mems_pkg;

  localparam int unsigned MEMS_DATA_W = 24;
  localparam int unsigned WD_W        = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_WAIT_BUSY = 3'd2;
  localparam state_t ST_WAIT_DONE = 3'd3;
  localparam state_t ST_ACK       = 3'd4;

  localparam logic GNT_SCAN = 1'b0;
  localparam logic GNT_HOST = 1'b1;

endpackage

// File: rtl/mems_spi_watchdog.sv
// Cycle counter shared by the busy-rise and busy-fall windows of a transfer.
module mems_spi_watchdog
  import mems_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [WD_W-1:0] limit,
  output logic            expired_c
);

  localparam int unsigned CMP_W = WD_W + 1;

  logic [WD_W-1:0] cnt_q;

  // The cycle that enters a window is counted as its first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= WD_W'(1);
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WD_W'(1);
    end
  end

  assign expired_c = en && ((CMP_W'(cnt_q) + CMP_W'(1)) >= CMP_W'(limit));

endmodule

// File: rtl/mems_spi_arbiter.sv
// Round-robin arbiter sharing the MEMS DAC SPI master between scan and host requesters.
module mems_spi_arbiter
  import mems_pkg::*;
#(
  parameter int unsigned DATA_W    = MEMS_DATA_W,
  parameter int unsigned BUSY_WAIT = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [DATA_W-1:0] scan_data,
  output logic              scan_ack,
  input  logic              host_req,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  input  logic              pause,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_busy,
  output logic              grant_host,
  output logic              xfer_err,
  output logic              spi_timeout,
  output logic [15:0]       xfer_count
);

  state_t          state_q;
  state_t          state_d;
  logic            rr_host_next_q;
  logic            scan_ok_c;
  logic            pick_host_c;
  logic            grant_c;
  logic            set_err_c;
  logic            set_timeout_c;
  logic            wd_clr_c;
  logic            wd_en_c;
  logic            wd_expired_c;
  logic [WD_W-1:0] wd_limit_c;

  // Watchdog controls depend only on state and busy, keeping the FSM loop-free.
  assign wd_en_c    = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  assign wd_clr_c   = (state_q == ST_START) || ((state_q == ST_WAIT_BUSY) && spi_busy);
  assign wd_limit_c = (state_q == ST_WAIT_DONE) ? WD_W'(TIMEOUT) : WD_W'(BUSY_WAIT);

  mems_spi_watchdog u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .limit     (wd_limit_c),
    .expired_c (wd_expired_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and arbitration decision.
  always_comb begin
    state_d       = state_q;
    grant_c       = 1'b0;
    set_err_c     = 1'b0;
    set_timeout_c = 1'b0;
    scan_ok_c     = scan_req && !pause;
    pick_host_c   = host_req && (!scan_ok_c || rr_host_next_q);
    case (state_q)
      ST_IDLE: begin
        if (host_req || scan_ok_c) begin
          grant_c = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (wd_expired_c) begin
          state_d   = ST_ACK;
          set_err_c = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!spi_busy) begin
          state_d = ST_ACK;
        end else if (wd_expired_c) begin
          state_d       = ST_ACK;
          set_err_c     = 1'b1;
          set_timeout_c = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, derived from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_start      <= 1'b0;
      spi_data       <= '0;
      grant_host     <= GNT_SCAN;
      rr_host_next_q <= 1'b1;
      scan_ack       <= 1'b0;
      host_ack       <= 1'b0;
      xfer_err       <= 1'b0;
      spi_timeout    <= 1'b0;
      xfer_count     <= '0;
    end else begin
      spi_start <= (state_d == ST_START) && (state_q == ST_IDLE);
      scan_ack  <= (state_d == ST_ACK) && (grant_host == GNT_SCAN);
      host_ack  <= (state_d == ST_ACK) && (grant_host == GNT_HOST);
      xfer_err  <= set_err_c;
      if (grant_c) begin
        spi_data       <= pick_host_c ? host_data : scan_data;
        grant_host     <= pick_host_c ? GNT_HOST : GNT_SCAN;
        rr_host_next_q <= !pick_host_c;
      end
      if (set_timeout_c) begin
        spi_timeout <= 1'b1;
      end
      if (state_q == ST_ACK) begin
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

endmodule
